// File: rtl/cubic_eval_arbiter.sv
// Round-robin, packet-locked arbiter sharing one cubic evaluator among N_REQ
// AXI-stream requesters; an in-order tag FIFO steers results back to their owners.
module cubic_eval_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_tvalid,
  output logic [N_REQ-1:0]             req_tready,
  input  logic [N_REQ*DATA_W-1:0]      req_tdata,
  input  logic [N_REQ-1:0]             req_tlast,
  output logic                         eval_tvalid,
  input  logic                         eval_tready,
  output logic [DATA_W-1:0]            eval_tdata,
  output logic                         eval_tlast,
  input  logic                         res_tvalid,
  output logic                         res_tready,
  input  logic [DATA_W-1:0]            res_tdata,
  input  logic                         res_tlast,
  output logic [N_REQ-1:0]             rsp_tvalid,
  input  logic [N_REQ-1:0]             rsp_tready,
  output logic [DATA_W-1:0]            rsp_tdata,
  output logic                         rsp_tlast,
  output logic [$clog2(MAX_OUT):0]     outstanding,
  output logic                         orphan_err
);

  localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  typedef enum logic {
    ARB  = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   grant_q, grant_d;
  logic [TAG_W-1:0]   ptr_q, ptr_d;
  logic [TAG_W-1:0]   tag_mem_q [MAX_OUT];
  logic [TAG_W-1:0]   tag_mem_d [MAX_OUT];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               orphan_q, orphan_d;

  logic               busy, full, empty, push, pop;
  logic               sel_valid, sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic [TAG_W-1:0]   head_tag;
  logic               head_ready;
  logic               found;
  logic [TAG_W-1:0]   pick;
  logic [TAG_W:0]     cand_sum;

  assign busy  = (state_q == BUSY);
  assign full  = (count_q == CNT_W'(MAX_OUT));
  assign empty = (count_q == '0);

  // Mux the granted requester onto the evaluator input
  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    req_tready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == TAG_W'(i)) begin
        sel_valid     = req_tvalid[i];
        sel_last      = req_tlast[i];
        sel_data      = req_tdata[i*DATA_W +: DATA_W];
        req_tready[i] = busy & eval_tready & ~full;
      end
    end
  end

  assign eval_tvalid = busy & sel_valid & ~full;
  assign eval_tdata  = sel_data;
  assign eval_tlast  = sel_last;
  assign push        = eval_tvalid & eval_tready;

  assign head_tag = tag_mem_q[rd_ptr_q];

  // Results go to the owner of the head tag; with no tags they are sunk
  always_comb begin
    head_ready = 1'b0;
    rsp_tvalid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (head_tag == TAG_W'(i)) begin
        head_ready    = rsp_tready[i];
        rsp_tvalid[i] = res_tvalid & ~empty;
      end
    end
  end

  assign res_tready  = empty | head_ready;
  assign pop         = res_tvalid & res_tready & ~empty;
  assign rsp_tdata   = res_tdata;
  assign rsp_tlast   = res_tlast;
  assign outstanding = count_q;
  assign orphan_err  = orphan_q;

  // Round-robin search starting at ptr; the grant is held until the TLAST beat issues
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    found    = 1'b0;
    pick     = '0;
    cand_sum = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (TAG_W+1)'(i);
      if (cand_sum >= (TAG_W+1)'(N_REQ)) begin
        cand_sum = cand_sum - (TAG_W+1)'(N_REQ);
      end
      if (!found && req_tvalid[cand_sum[TAG_W-1:0]]) begin
        found = 1'b1;
        pick  = cand_sum[TAG_W-1:0];
      end
    end
    case (state_q)
      ARB: begin
        if (found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (push && sel_last) begin
          state_d = ARB;
          ptr_d   = (grant_q == TAG_W'(N_REQ-1)) ? '0 : grant_q + TAG_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    orphan_d  = orphan_q | (empty & res_tvalid);
    if (push) begin
      tag_mem_d[wr_ptr_q] = grant_q;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB;
      grant_q  <= '0;
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      orphan_q  <= orphan_d;
      tag_mem_q <= tag_mem_d;
    end
  end

endmodule

// File: tb/tb_cubic_eval_arbiter.sv
// Self-checking bench for cubic_eval_arbiter: directed scenarios plus a randomized
// run checked against a packet-level round-robin and in-order-return model.
module tb_cubic_eval_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int M  = 8;
  localparam int CW = $clog2(M) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_tvalid, req_tready, req_tlast;
  logic [N*W-1:0]  req_tdata;
  logic            eval_tvalid, eval_tready, eval_tlast;
  logic [W-1:0]    eval_tdata;
  logic            res_tvalid, res_tready, res_tlast;
  logic [W-1:0]    res_tdata;
  logic [N-1:0]    rsp_tvalid, rsp_tready;
  logic [W-1:0]    rsp_tdata;
  logic            rsp_tlast;
  logic [CW-1:0]   outstanding;
  logic            orphan_err;

  always #5 clk = ~clk;

  cubic_eval_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_OUT(M)) dut (
    .clk(clk), .rst(rst),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata), .req_tlast(req_tlast),
    .eval_tvalid(eval_tvalid), .eval_tready(eval_tready), .eval_tdata(eval_tdata), .eval_tlast(eval_tlast),
    .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tdata(res_tdata), .res_tlast(res_tlast),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata), .rsp_tlast(rsp_tlast),
    .outstanding(outstanding), .orphan_err(orphan_err)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] src_data [N][32];
  bit           src_last [N][32];
  int           src_len  [N];
  int           src_idx  [N];
  bit           gap_en;
  logic [N-1:0] hs_req;
  bit           eval_hs, res_hs;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    int           t;
    int           owner;
  } ev_t;
  ev_t evq[$];

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_idx[i] = 0;
    end
    gap_en = 1'b0;
  endtask

  task automatic load_packet(input int r, input int n, input logic [W-1:0] d0, input bit rnd);
    for (int k = 0; k < n; k++) begin
      src_data[r][src_len[r]] = rnd ? W'($urandom) : d0 + W'(k);
      src_last[r][src_len[r]] = (k == n-1);
      src_len[r]++;
    end
  endtask

  // Present each source's current beat, then latch which handshakes will occur
  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_idx[i] < src_len[i]) begin
        bit first;
        first = (src_idx[i] == 0) || src_last[i][src_idx[i]-1];
        req_tvalid[i]       = first || !gap_en || ($urandom_range(2) != 0);
        req_tdata[i*W +: W] = src_data[i][src_idx[i]];
        req_tlast[i]        = src_last[i][src_idx[i]];
      end else begin
        req_tvalid[i]       = 1'b0;
        req_tdata[i*W +: W] = '0;
        req_tlast[i]        = 1'b0;
      end
    end
    #1;
    hs_req  = req_tvalid & req_tready;
    eval_hs = eval_tvalid && eval_tready;
    res_hs  = res_tvalid && res_tready;
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (hs_req[i]) src_idx[i]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b0;
    req_tvalid  = '0;
    req_tdata   = '0;
    req_tlast   = '0;
    eval_tready = 1'b0;
    res_tvalid  = 1'b0;
    res_tdata   = '0;
    res_tlast   = 1'b0;
    rsp_tready  = '0;
    clear_sources();
    evq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int rr_winner(input int p);
    for (int k = 0; k < N; k++) begin
      int r;
      r = (p + k) % N;
      if (src_idx[r] < src_len[r]) return r;
    end
    return -1;
  endfunction

  task automatic test_reset();
    bit got;
    do_reset();
    eval_tready = 1'b1;
    load_packet(0, 1, 32'h0000_00F0, 1'b0);
    load_packet(2, 4, 32'h0000_0200, 1'b0);
    for (int c = 0; c < 20 && src_idx[2] < 2; c++) begin
      drive_inputs();
      advance();
    end
    checks++;
    if (outstanding !== CW'(3)) begin
      errors++; $display("[TB] FAIL reset_pre_outstanding: got %0d expected 3", outstanding);
    end
    drive_inputs();
    rst = 1'b0;
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if (req_tready !== '0) begin
        errors++; $display("[TB] FAIL reset_req_tready: got %b expected 0000", req_tready);
      end
      checks++;
      if (eval_tvalid !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_eval_tvalid: got %b expected 0", eval_tvalid);
      end
      checks++;
      if (rsp_tvalid !== '0 || res_tready !== 1'b1) begin
        errors++; $display("[TB] FAIL reset_rsp: got rsp_tvalid=%b res_tready=%b expected 0000/1", rsp_tvalid, res_tready);
      end
      checks++;
      if (outstanding !== '0 || orphan_err !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_counters: got outstanding=%0d orphan=%b expected 0/0", outstanding, orphan_err);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    clear_sources();
    for (int r = 0; r < N; r++) load_packet(r, 1, 32'h0000_00A0 + W'(r), 1'b0);
    drive_inputs();
    checks++;
    if (eval_tvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL grant_latency: got eval_tvalid=%b expected 0", eval_tvalid);
    end
    advance();
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      drive_inputs();
      if (eval_hs) begin
        got = 1'b1;
        checks++;
        if (eval_tdata !== 32'h0000_00A0) begin
          errors++; $display("[TB] FAIL reset_first_grant: got %h expected 000000a0", eval_tdata);
        end
      end
      advance();
    end
    checks++;
    if (!got) begin
      errors++; $display("[TB] FAIL reset_first_grant_timeout: got none expected a handshake");
    end
  endtask

  task automatic test_round_robin();
    int           n;
    int           hs_cyc [8];
    logic [W-1:0] hs_dat [8];
    logic         hs_lst [8];
    logic [W-1:0] exp_dat [6];
    do_reset();
    eval_tready = 1'b1;
    load_packet(0, 2, 32'h1000_0000, 1'b0);
    load_packet(1, 2, 32'h2000_0000, 1'b0);
    load_packet(3, 2, 32'h4000_0000, 1'b0);
    exp_dat = '{32'h1000_0000, 32'h1000_0001, 32'h2000_0000, 32'h2000_0001, 32'h4000_0000, 32'h4000_0001};
    n = 0;
    for (int c = 0; c < 20; c++) begin
      drive_inputs();
      if (eval_hs && n < 8) begin
        hs_cyc[n] = c; hs_dat[n] = eval_tdata; hs_lst[n] = eval_tlast; n++;
      end
      advance();
    end
    checks++;
    if (n !== 6) begin
      errors++; $display("[TB] FAIL rr_beat_count: got %0d expected 6", n);
    end else begin
      checks++;
      if (hs_cyc[0] < 1) begin
        errors++; $display("[TB] FAIL rr_grant_latency: got cycle %0d expected >=1", hs_cyc[0]);
      end
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (hs_dat[k] !== exp_dat[k] || hs_lst[k] !== (k % 2 == 1)) begin
          errors++; $display("[TB] FAIL rr_order[%0d]: got %h/%b expected %h/%b", k, hs_dat[k], hs_lst[k], exp_dat[k], (k % 2 == 1));
        end
        if (k > 0) begin
          checks++;
          if (hs_cyc[k] - hs_cyc[k-1] !== ((k % 2 == 0) ? 2 : 1)) begin
            errors++; $display("[TB] FAIL rr_spacing[%0d]: got %0d expected %0d", k, hs_cyc[k] - hs_cyc[k-1], (k % 2 == 0) ? 2 : 1);
          end
        end
      end
    end
    checks++;
    if (outstanding !== CW'(6)) begin
      errors++; $display("[TB] FAIL rr_outstanding: got %0d expected 6", outstanding);
    end
  endtask

  task automatic test_passthrough();
    int           n;
    bit           loaded1;
    logic [N-1:0] got_v [4];
    logic [W-1:0] got_d [4];
    logic         got_l [4];
    logic         got_r [4];
    do_reset();
    eval_tready = 1'b1;
    rsp_tready  = '1;
    load_packet(2, 1, 32'h3F80_0000, 1'b0);
    loaded1 = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      res_tvalid = (evq.size() > 0) && (evq[0].t <= c);
      res_tdata  = (evq.size() > 0) ? evq[0].d : '0;
      res_tlast  = (evq.size() > 0) ? evq[0].l : 1'b0;
      drive_inputs();
      if (rsp_tvalid !== '0 && n < 4) begin
        got_v[n] = rsp_tvalid; got_d[n] = rsp_tdata; got_l[n] = rsp_tlast; got_r[n] = res_tready; n++;
      end
      if (res_hs) void'(evq.pop_front());
      if (eval_hs) evq.push_back('{d: eval_tdata, l: eval_tlast, t: c + 3, owner: 0});
      advance();
      if (!loaded1 && src_idx[2] == 1) begin
        load_packet(1, 1, 32'h4000_0000, 1'b0);
        loaded1 = 1'b1;
      end
    end
    res_tvalid = 1'b0;
    checks++;
    if (n !== 2) begin
      errors++; $display("[TB] FAIL pt_rsp_count: got %0d expected 2", n);
    end else begin
      checks++;
      if (got_v[0] !== 4'b0100 || got_d[0] !== 32'h3F80_0000 || got_l[0] !== 1'b1 || got_r[0] !== 1'b1) begin
        errors++; $display("[TB] FAIL pt_rsp0: got %b/%h/%b/%b expected 0100/3f800000/1/1", got_v[0], got_d[0], got_l[0], got_r[0]);
      end
      checks++;
      if (got_v[1] !== 4'b0010 || got_d[1] !== 32'h4000_0000 || got_l[1] !== 1'b1 || got_r[1] !== 1'b1) begin
        errors++; $display("[TB] FAIL pt_rsp1: got %b/%h/%b/%b expected 0010/40000000/1/1", got_v[1], got_d[1], got_l[1], got_r[1]);
      end
    end
  endtask

  task automatic test_full();
    int n;
    do_reset();
    eval_tready = 1'b1;
    rsp_tready  = 4'b0001;
    load_packet(0, 12, 32'h5000_0000, 1'b0);
    n = 0;
    for (int c = 0; c < 15; c++) begin
      drive_inputs();
      if (eval_hs) n++;
      advance();
    end
    checks++;
    if (n !== M) begin
      errors++; $display("[TB] FAIL full_accept_count: got %0d expected %0d", n, M);
    end
    res_tvalid = 1'b1;
    res_tdata  = 32'h5000_0000;
    drive_inputs();
    checks++;
    if (req_tready[0] !== 1'b0 || outstanding !== CW'(M)) begin
      errors++; $display("[TB] FAIL full_stall: got ready=%b outstanding=%0d expected 0/%0d", req_tready[0], outstanding, M);
    end
    checks++;
    if (res_tready !== 1'b1 || rsp_tvalid !== 4'b0001) begin
      errors++; $display("[TB] FAIL full_pop: got res_tready=%b rsp_tvalid=%b expected 1/0001", res_tready, rsp_tvalid);
    end
    advance();
    res_tvalid = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      drive_inputs();
      if (eval_hs) n++;
      advance();
    end
    checks++;
    if (n !== 1) begin
      errors++; $display("[TB] FAIL full_refill_count: got %0d expected 1", n);
    end
    checks++;
    if (outstanding !== CW'(M)) begin
      errors++; $display("[TB] FAIL full_refill_outstanding: got %0d expected %0d", outstanding, M);
    end
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    eval_tready = 1'b1;
    load_packet(1, 1, 32'h6000_0000, 1'b0);
    for (int c = 0; c < 10 && src_idx[1] < 1; c++) begin
      drive_inputs();
      advance();
    end
    checks++;
    if (outstanding !== CW'(1)) begin
      errors++; $display("[TB] FAIL bp_issue: got outstanding=%0d expected 1", outstanding);
    end
    res_tvalid = 1'b1;
    res_tdata  = 32'h6000_0000;
    rsp_tready = 4'b1101;
    for (int c = 0; c < 4; c++) begin
      drive_inputs();
      checks++;
      if (res_tready !== 1'b0 || rsp_tvalid !== 4'b0010 || outstanding !== CW'(1)) begin
        errors++; $display("[TB] FAIL bp_stall: got res_tready=%b rsp_tvalid=%b outstanding=%0d expected 0/0010/1", res_tready, rsp_tvalid, outstanding);
      end
      advance();
    end
    rsp_tready = 4'b0010;
    drive_inputs();
    checks++;
    if (res_tready !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_release: got res_tready=%b expected 1", res_tready);
    end
    advance();
    res_tvalid = 1'b0;
    drive_inputs();
    checks++;
    if (outstanding !== '0) begin
      errors++; $display("[TB] FAIL bp_drain: got outstanding=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    rsp_tready = '1;
    res_tvalid = 1'b1;
    res_tdata  = 32'hDEAD_BEEF;
    drive_inputs();
    checks++;
    if (res_tready !== 1'b1 || rsp_tvalid !== '0) begin
      errors++; $display("[TB] FAIL orphan_drop: got res_tready=%b rsp_tvalid=%b expected 1/0000", res_tready, rsp_tvalid);
    end
    advance();
    res_tvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_inputs();
      checks++;
      if (orphan_err !== 1'b1 || rsp_tvalid !== '0 || outstanding !== '0) begin
        errors++; $display("[TB] FAIL orphan_sticky: got orphan=%b rsp_tvalid=%b outstanding=%0d expected 1/0000/0", orphan_err, rsp_tvalid, outstanding);
      end
      advance();
    end
    do_reset();
    drive_inputs();
    checks++;
    if (orphan_err !== 1'b0) begin
      errors++; $display("[TB] FAIL orphan_clear: got %b expected 0", orphan_err);
    end
  endtask

  task automatic test_random();
    int  cur, mptr, who, cyc;
    bit  prev_last, done;
    do_reset();
    for (int r = 0; r < N; r++) begin
      int np;
      np = $urandom_range(4, 2);
      for (int p = 0; p < np; p++) load_packet(r, $urandom_range(4, 1), '0, 1'b1);
    end
    gap_en    = 1'b1;
    cur       = -1;
    mptr      = 0;
    prev_last = 1'b0;
    done      = 1'b0;
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      eval_tready = ($urandom_range(3) != 0);
      rsp_tready  = N'($urandom);
      res_tvalid  = (evq.size() > 0) && (evq[0].t <= cyc) && ($urandom_range(3) != 0);
      res_tdata   = (evq.size() > 0) ? evq[0].d : '0;
      res_tlast   = (evq.size() > 0) ? evq[0].l : 1'b0;
      drive_inputs();
      checks++;
      if (outstanding !== CW'(evq.size())) begin
        errors++; $display("[TB] FAIL rnd_outstanding: got %0d expected %0d", outstanding, evq.size());
      end
      if (prev_last || evq.size() == M) begin
        checks++;
        if (eval_tvalid !== 1'b0) begin
          errors++; $display("[TB] FAIL rnd_idle: got eval_tvalid=%b expected 0 (inflight %0d)", eval_tvalid, evq.size());
        end
      end
      if (res_tvalid) begin
        checks++;
        if (rsp_tvalid !== (N'(1) << evq[0].owner) || rsp_tdata !== evq[0].d || res_tready !== rsp_tready[evq[0].owner]) begin
          errors++; $display("[TB] FAIL rnd_rsp: got %b/%h/%b expected %b/%h/%b", rsp_tvalid, rsp_tdata, res_tready, N'(1) << evq[0].owner, evq[0].d, rsp_tready[evq[0].owner]);
        end
      end else begin
        checks++;
        if (rsp_tvalid !== '0) begin
          errors++; $display("[TB] FAIL rnd_rsp_idle: got %b expected 0000", rsp_tvalid);
        end
      end
      prev_last = 1'b0;
      if (res_hs && evq.size() > 0) void'(evq.pop_front());
      if (eval_hs) begin
        who = (cur >= 0) ? cur : rr_winner(mptr);
        checks++;
        if (who < 0) begin
          errors++; $display("[TB] FAIL rnd_spurious_beat: got data %h expected no beat", eval_tdata);
        end else begin
          if (eval_tdata !== src_data[who][src_idx[who]] || eval_tlast !== src_last[who][src_idx[who]] || hs_req !== (N'(1) << who)) begin
            errors++; $display("[TB] FAIL rnd_eval_beat: got %h/%b ready=%b expected %h/%b ready=%b", eval_tdata, eval_tlast, hs_req, src_data[who][src_idx[who]], src_last[who][src_idx[who]], N'(1) << who);
          end
          evq.push_back('{d: eval_tdata, l: eval_tlast, t: cyc + 1 + $urandom_range(3), owner: who});
          if (eval_tlast) begin
            cur       = -1;
            mptr      = (who + 1) % N;
            prev_last = 1'b1;
          end else begin
            cur = who;
          end
        end
      end
      advance();
      done = (evq.size() == 0);
      for (int r = 0; r < N; r++) if (src_idx[r] < src_len[r]) done = 1'b0;
    end
    res_tvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("[TB] FAIL rnd_timeout: got incomplete after %0d cycles expected drain", cyc);
    end
  endtask

  initial begin
    rst         = 1'b0;
    req_tvalid  = '0;
    req_tdata   = '0;
    req_tlast   = '0;
    eval_tready = 1'b0;
    res_tvalid  = 1'b0;
    res_tdata   = '0;
    res_tlast   = 1'b0;
    rsp_tready  = '0;
    test_reset();
    test_round_robin();
    test_passthrough();
    test_full();
    test_rsp_backpressure();
    test_orphan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cubic_eval_arbiter.md
# cubic_eval_arbiter

Shares one Horner cubic evaluator pipeline among `N_REQ` AXI-stream requesters. Arbitration is round-robin with packet lock on TLAST. Every beat issued to the evaluator carries a requester tag, which is held in an in-order tag FIFO. Each result coming back from the evaluator is steered to the requester whose tag sits at the FIFO head. The block sits between the requester-side stream sources and the evaluator's `prev`/`next` ports.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: stream data width; IEEE-754 single-precision payload, never interpreted here.
- `MAX_OUT`, 8: tag FIFO depth, i.e. the maximum number of beats in flight inside the evaluator; power of two.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-low (asserts immediately when low, releases synchronously to `clk`).
- `req_tvalid`  in  N_REQ  per-requester valid.
- `req_tready`  out  N_REQ  per-requester ready.
- `req_tdata`  in  N_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- `req_tlast`  in  N_REQ  end of packet.
- `eval_tvalid`/`eval_tready`/`eval_tdata`/`eval_tlast`  out/in/out/out  1/1/DATA_W/1  master to the evaluator input.
- `res_tvalid`/`res_tready`/`res_tdata`/`res_tlast`  in/out/in/in  1/1/DATA_W/1  slave from the evaluator output.
- `rsp_tvalid`  out  N_REQ  per-requester response valid; one-hot or zero.
- `rsp_tready`  in  N_REQ  per-requester response ready.
- `rsp_tdata`/`rsp_tlast`  out  DATA_W/1  shared response bus; copies of `res_tdata`/`res_tlast`.
- `outstanding`  out  $clog2(MAX_OUT)+1  current tag FIFO occupancy.
- `orphan_err`  out  1  sticky; set when a result arrives while the tag FIFO is empty.

## Operation
- Arbiter FSM, 2 states:
  - **ARB**: `grant` register invalid. Search `req_tvalid` round-robin, starting at `ptr`. On a hit at index k, register `grant=k` and go to BUSY. With no valid requester, stay in ARB.
  - **BUSY**: the granted requester is connected to the eval channel.
    - `eval_tvalid = req_tvalid[grant] & ~full`.
    - `req_tready[grant] = eval_tready & ~full`.
    - All other `req_tready` are 0.
    - `eval_tdata`/`eval_tlast` are muxed from `grant`.
    - On a handshake with `req_tlast=1`: go to ARB and set `ptr = (grant+1) mod N_REQ`.
- The grant is never revoked mid-packet. A requester that drops `tvalid` mid-packet keeps the grant.
- Tag FIFO:
  - Push `grant` on every eval handshake.
  - Pop on every response handshake.
  - `full` and `empty` are derived from the registered count.
  - Simultaneous push and pop leave the count unchanged; this is legal when full, because `full` already blocks push.
- Response steering:
  - FIFO not empty: `rsp_tvalid[head] = res_tvalid` and `res_tready = rsp_tready[head]`.
  - FIFO empty: `res_tready = 1` (the result is dropped). If `res_tvalid` is high, set `orphan_err`. `rsp_tvalid` stays 0.
- The evaluator must return results in issue order, one result per issued beat. The block relies on this and does not check it.

## Timing
- Reset values:
  - `req_tready=0`, `eval_tvalid=0`, `rsp_tvalid=0`, `res_tready=1`.
  - `outstanding=0`, `orphan_err=0`.
  - State ARB, `ptr=0`, FIFO empty.
- A reset mid-packet abandons the grant and all tags; the evaluator must share `rst`.
- Grant latency: a valid seen in ARB at cycle t gives the first eval handshake no earlier than t+1.
- Packet turnaround: the TLAST handshake at cycle t puts the FSM in ARB at t+1, and the next packet's first beat can issue at t+2. Sustained rate is therefore 1 beat/cycle within a packet, with a 1-cycle bubble between packets.
- The eval path is combinational from the `req_*` inputs; there is no added latency and no skid buffer.
- The response path is combinational from `res_*` through to `rsp_*`.
- `outstanding` updates one cycle after a push or pop handshake.

## Test plan
- Reset with `rst=0` mid-packet and `outstanding=3` -> all outputs at their reset values while `rst` is low; after release, requester 0 is served first.
- Requesters 0, 1 and 3 each hold a 2-beat packet valid at the same time -> eval order is 0,0,1,1,3,3 with TLAST on beats 2, 4 and 6, and a 1-cycle bubble between packets.
- Evaluator modelled as a 3-cycle passthrough. Requester 2 sends 0x3F800000 and requester 1 sends 0x40000000 -> `rsp_tvalid[2]` with 0x3F800000, then `rsp_tvalid[1]` with 0x40000000, in that order.
- `MAX_OUT=8`, evaluator `res_tvalid` held 0, requester 0 streaming -> exactly 8 beats accepted, then `req_tready[0]=0` with `outstanding=8`. One response pop re-enables exactly one push.
- `rsp_tready[1]=0` while the head tag is 1 -> `res_tready=0`, the evaluator stalls, and `outstanding` holds until `rsp_tready[1]=1`.
- `res_tvalid=1` pulse with the FIFO empty -> result dropped, `orphan_err=1` until reset, and no `rsp_tvalid` asserted.
